mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single ram512x8 port between instruction fetch (IF) and data load/store (DM) requesters.
//  Sequences the RAM's MOV/ReadWrite/OP/Address/DataIn strobes and the MOC completion handshake.
//  Sits between Control_Unit/MAR-MDR and the RAM; it replaces direct control-unit driving of MOV/RW.
// PARAMETERS
//  TIMEOUT_CYCLES  16  WAIT-state cycles before a missing MOC is declared an error (MEM_ARB_TIMEOUT_EN only)
//  MEM_BYTES       512 addressable bytes; addresses >= MEM_BYTES are out of range
// PORTS
//  Clk        in   1   clock; all state changes on posedge
//  Clr        in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request; held with if_addr until if_ack
//  if_addr    in   32  fetch byte address (always word read, OP 6'b100011)
//  if_ack     out  1   one-cycle completion pulse for fetch
//  if_rdata   out  32  fetched word, valid while if_ack=1
//  dm_req     in   1   data request; held with dm_* fields until dm_ack
//  dm_rw      in   1   1=read, 0=write (RAM ReadWrite encoding)
//  dm_op      in   6   load/store opcode: 100011/100001/100000 read, 101011/101001/101000 write
//  dm_addr    in   32  data byte address
//  dm_wdata   in   32  store data
//  dm_ack     out  1   one-cycle completion pulse for data
//  dm_rdata   out  32  load data, valid while dm_ack=1
//  dm_err     out  1   qualifies dm_ack: illegal op, misalignment, range or timeout
//  mem_mov    out  1   RAM MOV strobe
//  mem_rw     out  1   RAM ReadWrite
//  mem_op     out  6   RAM OP
//  mem_addr   out  32  RAM Address
//  mem_wdata  out  32  RAM DataIn
//  mem_moc    in   1   RAM MOC
//  mem_rdata  in   32  RAM DataOut
// BEHAVIOUR
//  Reset (Clr=0, async): state=IDLE; all outputs 0; last_grant=DM. In-flight access discarded; requester reissues.
//  FSM: IDLE -> GRANT -> STROBE -> WAIT -> RESP -> IDLE; registered outputs.
//   IDLE: arbitrate any req. Both pending -> grant port != last_grant (round-robin); fetch wins first tie.
//   GRANT: latch winner's addr/op/rw/wdata onto mem_*; mem_mov=0. DM check here: op/rw mismatch,
//     word addr[1:0]!=0, half addr[0]!=0, or addr+size>MEM_BYTES -> RESP with dm_err=1, no MOV.
//   STROBE: mem_mov=1 (rising edge starts the RAM access).
//   WAIT: mem_mov held 1; mem_moc ignored until WAIT; mem_moc=1 sampled -> capture mem_rdata, go RESP.
//   RESP: mem_mov=0; winner ack=1 for exactly one cycle; rdata valid (0 for writes/errors); update last_grant.
//  Min latency: req sampled at cycle N -> ack at N+4. mem_* fields stable GRANT..RESP.
//  Requester deasserts req the cycle after ack; req still high in IDLE is a new request.
//  Req changes while not granted are legal; granted fields latched in GRANT, later changes ignored.
//  if_ack and dm_ack never both high; dm_err=0 whenever dm_ack=0. Fetch has no error output.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined: WAIT counter from 0; reaching TIMEOUT_CYCLES without MOC -> RESP, mem_mov=0,
//   rdata=0, dm_err=1 (DM) or if_ack with if_rdata=32'hFFFF_FFFF (IF). Counter cleared on WAIT entry.
//  Undefined: WAIT holds indefinitely until mem_moc=1; no counter logic present.
// TESTING
//  1 Clr=0 mid-WAIT -> all outputs 0 same cycle (no Clk edge); after release, IDLE, first tie goes to IF.
//  2 IF req addr 0x10, RAM holds 0x8C010004 -> mem_op=100011, mem_mov high 2 cycles, if_ack at N+4, data matches.
//  3 IF+DM req together repeatedly -> grants alternate IF,DM,IF,DM; never two acks same cycle.
//  4 DM write op 101001 addr 0x21 -> dm_ack+dm_err at N+2, mem_mov never rises; addr 0x1FE -> ok, RAM updated.
//  5 DM read op 100011 addr 0x1FC -> ok; addr 0x200 -> dm_err=1, no MOV; op 100011 with dm_rw=0 -> dm_err=1.
//  6 MEM_ARB_TIMEOUT_EN, mem_moc tied 0 -> dm_ack+dm_err after 16 WAIT cycles, mem_mov drops, next req served.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF/DM) handshakes and ram512x8 strobes seen by mem_port_arbiter.
// slave = arbiter view, master = requester/RAM side view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_rw;
  logic [5:0]  dm_op;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_mov;
  logic        mem_rw;
  logic [5:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_moc;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_rw, dm_op, dm_addr, dm_wdata, mem_moc, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, dm_err, mem_mov, mem_rw, mem_op, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_rw, dm_op, dm_addr, dm_wdata, mem_moc, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, dm_err, mem_mov, mem_rw, mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single ram512x8 port between fetch and data requesters.
// Optional MOC watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MEM_BYTES      = 512
) (
  input logic               Clk,
  input logic               Clr,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GRANT, STROBE, WAIT, RESP} state_e;
  localparam logic [5:0] OP_LW = 6'b100011;

  state_e      state_q, state_d;
  logic        gnt_dm_q, gnt_dm_d;
  logic        last_dm_q, last_dm_d;
  logic        mov_q, mov_d;
  logic        rw_q, rw_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        dm_err_q, dm_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        pick_dm;
  logic        op_legal, op_rd, dm_bad;
  logic [2:0]  op_size;
  logic [32:0] end_addr;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // On a tie the port that did not win last time goes first.
  assign pick_dm = bus.dm_req && (!bus.if_req || !last_dm_q);

  // DM legality is judged on the latched fields while in GRANT.
  always_comb begin
    op_legal = 1'b1;
    op_rd    = 1'b0;
    op_size  = 3'd0;
    case (op_q)
      6'b100011: begin op_size = 3'd4; op_rd = 1'b1; end
      6'b100001: begin op_size = 3'd2; op_rd = 1'b1; end
      6'b100000: begin op_size = 3'd1; op_rd = 1'b1; end
      6'b101011: op_size = 3'd4;
      6'b101001: op_size = 3'd2;
      6'b101000: op_size = 3'd1;
      default:   op_legal = 1'b0;
    endcase
    end_addr = {1'b0, addr_q} + {30'b0, op_size};
    dm_bad   = !op_legal || (op_rd != rw_q)
             || (op_size == 3'd4 && addr_q[1:0] != 2'b00)
             || (op_size == 3'd2 && addr_q[0])
             || (end_addr > 33'(MEM_BYTES));
  end

  always_comb begin
    state_d    = state_q;
    gnt_dm_d   = gnt_dm_q;
    last_dm_d  = last_dm_q;
    mov_d      = mov_q;
    rw_d       = rw_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_ack_d   = if_ack_q;
    dm_ack_d   = dm_ack_q;
    dm_err_d   = dm_err_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.if_req || bus.dm_req) begin
        state_d  = GRANT;
        gnt_dm_d = pick_dm;
        rw_d     = pick_dm ? bus.dm_rw    : 1'b1;
        op_d     = pick_dm ? bus.dm_op    : OP_LW;
        addr_d   = pick_dm ? bus.dm_addr  : bus.if_addr;
        wdata_d  = pick_dm ? bus.dm_wdata : 32'h0;
      end
      GRANT: begin
        if (gnt_dm_q && dm_bad) begin
          state_d    = RESP;
          dm_ack_d   = 1'b1;
          dm_err_d   = 1'b1;
          dm_rdata_d = 32'h0;
        end else begin
          state_d = STROBE;
          mov_d   = 1'b1;
        end
      end
      STROBE: begin
        state_d = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.mem_moc) begin
          state_d = RESP;
          mov_d   = 1'b0;
          if (gnt_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = rw_q ? bus.mem_rdata : 32'h0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          mov_d   = 1'b0;
          if (gnt_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_err_d   = 1'b1;
            dm_rdata_d = 32'h0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = 32'hFFFF_FFFF;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d    = IDLE;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        dm_err_d   = 1'b0;
        if_rdata_d = 32'h0;
        dm_rdata_d = 32'h0;
        last_dm_d  = gnt_dm_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q    <= IDLE;
      gnt_dm_q   <= 1'b0;
      last_dm_q  <= 1'b1;
      mov_q      <= 1'b0;
      rw_q       <= 1'b0;
      op_q       <= 6'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_dm_q   <= gnt_dm_d;
      last_dm_q  <= last_dm_d;
      mov_q      <= mov_d;
      rw_q       <= rw_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      dm_err_q   <= dm_err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.mem_mov   = mov_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_op    = op_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_err    = dm_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level model
// (grant order, latency, error rules, memory contents) and a behavioural ram512x8.
module tb_mem_port_arbiter;
  logic Clk = 1'b0;
  logic Clr = 1'b0;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT_CYCLES(16), .MEM_BYTES(512)) dut (.Clk(Clk), .Clr(Clr), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  // behavioural RAM: MOC rises once MOV has been high for 'delay' earlier cycles
  logic [7:0] ram  [512];
  logic [7:0] refm [512];
  bit   load_en   = 1'b0;
  bit   moc_block = 1'b0;
  int   delay     = 0;
  int   mov_cnt   = 0;
  bit   last_dm   = 1'b1;
  wire [8:0] ra = bus.mem_addr[8:0];

  assign bus.mem_moc = bus.mem_mov && !moc_block && (mov_cnt >= delay);

  always @(posedge Clk) begin
    mov_cnt <= bus.mem_mov ? mov_cnt + 1 : 0;
    if (load_en) ram <= refm;
    else if (bus.mem_mov && bus.mem_moc && !bus.mem_rw) begin
      case (bus.mem_op)
        6'b101011: begin
          ram[ra] <= bus.mem_wdata[31:24]; ram[ra+9'd1] <= bus.mem_wdata[23:16];
          ram[ra+9'd2] <= bus.mem_wdata[15:8]; ram[ra+9'd3] <= bus.mem_wdata[7:0];
        end
        6'b101001: begin ram[ra] <= bus.mem_wdata[15:8]; ram[ra+9'd1] <= bus.mem_wdata[7:0]; end
        6'b101000: ram[ra] <= bus.mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_rdata = 32'h0;
    case (bus.mem_op)
      6'b100011: bus.mem_rdata = {ram[ra], ram[ra+9'd1], ram[ra+9'd2], ram[ra+9'd3]};
      6'b100001: bus.mem_rdata = {16'h0, ram[ra], ram[ra+9'd1]};
      6'b100000: bus.mem_rdata = {24'h0, ram[ra]};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011: return 4;
      6'b100001, 6'b101001: return 2;
      6'b100000, 6'b101000: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit dm_is_err(input logic [5:0] op, input bit rw, input logic [31:0] a);
    int sz;
    bit rd;
    sz = size_of(op);
    rd = (op == 6'b100011) || (op == 6'b100001) || (op == 6'b100000);
    if (sz == 0) return 1'b1;
    if (rd != rw) return 1'b1;
    if (a % sz != 0) return 1'b1;
    return (longint'(a) + sz > 512);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [5:0] op, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = size_of(op);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = {v[23:0], refm[(a + i) % 512]};
    return v;
  endfunction

  task automatic load_ram();
    @(negedge Clk); load_en = 1'b1;
    @(negedge Clk); load_en = 1'b0;
  endtask

  // one arbitration episode: IF and/or DM request raised together, served to completion
  task automatic txn(input bit use_if, input bit use_dm, input logic [31:0] ia,
                     input logic [5:0] op, input bit rw, input logic [31:0] da, input logic [31:0] wd);
    bit if_done, dm_done, solo, dm_first, first_seen, exp_err;
    int cyc, movs, extra, sz;
    logic [31:0] exp_if, exp_dm;
    if_done  = !use_if;
    dm_done  = !use_dm;
    solo     = use_if ^ use_dm;
    dm_first = use_dm && (!use_if || !last_dm);
    exp_err  = use_dm && dm_is_err(op, rw, da);
    exp_if   = rd_ref(6'b100011, ia);
    exp_dm   = (exp_err || !rw) ? 32'h0 : rd_ref(op, da);
    extra    = (delay > 1) ? delay - 1 : 0;
    sz       = size_of(op);
    first_seen = 1'b0; cyc = 0; movs = 0;
    @(negedge Clk);
    bus.if_req = use_if; bus.if_addr = ia;
    bus.dm_req = use_dm; bus.dm_op = op; bus.dm_rw = rw; bus.dm_addr = da; bus.dm_wdata = wd;
    while (!(if_done && dm_done) && cyc < 200) begin
      @(negedge Clk); cyc++;
      if (bus.mem_mov) movs++;
      if (solo && bus.mem_mov && movs == 1) begin
        check("mem_op", 32'(bus.mem_op), use_dm ? 32'(op) : 32'h23);
        check("mem_addr", bus.mem_addr, use_dm ? da : ia);
      end
      check("ack_excl", 32'(bus.if_ack & bus.dm_ack), 32'h0);
      if (!bus.dm_ack) check("err_qual", 32'(bus.dm_err), 32'h0);
      if ((bus.if_ack || bus.dm_ack) && !first_seen) begin
        first_seen = 1'b1;
        check("grant_order", 32'(bus.dm_ack), 32'(dm_first));
      end
      if (bus.if_ack) begin
        check("if_rdata", bus.if_rdata, exp_if);
        if (solo) begin
          check("if_latency", cyc, 4 + extra);
          check("if_movs", movs, 2 + extra);
        end
        if_done = 1'b1; bus.if_req = 1'b0; last_dm = 1'b0;
      end
      if (bus.dm_ack) begin
        check("dm_err", 32'(bus.dm_err), 32'(exp_err));
        check("dm_rdata", bus.dm_rdata, exp_dm);
        if (solo) begin
          check("dm_latency", cyc, exp_err ? 2 : 4 + extra);
          check("dm_movs", movs, exp_err ? 0 : 2 + extra);
        end
        if (!exp_err && !rw) begin
          for (int i = 0; i < sz; i++) refm[(da + i) % 512] = wd[8*(sz-1-i) +: 8];
          for (int i = 0; i < sz; i++) check("ram_byte", 32'(ram[(da + i) % 512]), 32'(refm[(da + i) % 512]));
        end
        dm_done = 1'b1; bus.dm_req = 1'b0; last_dm = 1'b1;
      end
    end
    check("served", {if_done, dm_done}, 32'h3);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
  endtask

  logic [5:0] op_tab [7] = '{6'b100011, 6'b100001, 6'b100000, 6'b101011, 6'b101001, 6'b101000, 6'b110000};

  initial begin
    int sel, sz, cyc;
    bit got;
    logic [5:0] op;
    logic rw;
    logic [31:0] da, ia;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_rw = 0;
    bus.dm_op = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    for (int i = 0; i < 512; i++) refm[i] = 8'($urandom);
    #1;
    check("rst_mov", 32'(bus.mem_mov), 32'h0);
    check("rst_acks", {bus.if_ack, bus.dm_ack, bus.dm_err}, 32'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    #20 Clr = 1'b1;
    load_ram();

    // known fetch word
    refm[16] = 8'h8C; refm[17] = 8'h01; refm[18] = 8'h00; refm[19] = 8'h04;
    load_ram();
    delay = 0;
    txn(1, 0, 32'h10, 6'h0, 1'b0, 32'h0, 32'h0);
    check("fetch_word", rd_ref(6'b100011, 32'h10), 32'h8C010004);

    // asynchronous reset while stuck in WAIT
    moc_block = 1'b1;
    @(negedge Clk); bus.if_req = 1'b1; bus.if_addr = 32'h10;
    repeat (3) @(negedge Clk);
    check("pre_rst_mov", 32'(bus.mem_mov), 32'h1);
    #2 Clr = 1'b0;
    #1;
    check("arst_mov", 32'(bus.mem_mov), 32'h0);
    check("arst_addr", bus.mem_addr, 32'h0);
    check("arst_op", {26'h0, bus.mem_op}, 32'h0);
    check("arst_rw", 32'(bus.mem_rw), 32'h0);
    bus.if_req = 1'b0; moc_block = 1'b0; last_dm = 1'b1;
    @(negedge Clk); Clr = 1'b1;
    txn(1, 1, 32'h20, 6'b100011, 1'b1, 32'h40, 32'h0);

    // ties alternate
    for (int k = 0; k < 6; k++) begin
      delay = $urandom_range(0, 3);
      txn(1, 1, 32'($urandom_range(0, 127) * 4), 6'b100011, 1'b1, 32'($urandom_range(0, 127) * 4), 32'h0);
    end

    // directed DM boundaries
    delay = 1;
    txn(0, 1, 32'h0, 6'b101001, 1'b0, 32'h21, 32'hAAAA_BEEF);
    txn(0, 1, 32'h0, 6'b101001, 1'b0, 32'h1FE, 32'h1234_5678);
    txn(0, 1, 32'h0, 6'b100011, 1'b1, 32'h1FC, 32'h0);
    txn(0, 1, 32'h0, 6'b100011, 1'b1, 32'h200, 32'h0);
    txn(0, 1, 32'h0, 6'b100011, 1'b0, 32'h40, 32'h0);
    txn(0, 1, 32'h0, 6'b101011, 1'b0, 32'h1FD, 32'hDEAD_BEEF);

    // random mix
    for (int k = 0; k < 40; k++) begin
      sel   = $urandom_range(0, 2);
      op    = op_tab[$urandom_range(0, 6)];
      rw    = !op[3] ^ ($urandom_range(0, 7) == 0);
      sz    = size_of(op);
      da    = 32'($urandom_range(0, 131)) * 4 + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      ia    = 32'($urandom_range(0, 127) * 4);
      delay = $urandom_range(0, 3);
      txn(sel != 1, sel != 0, ia, op, rw, da, $urandom);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    moc_block = 1'b1;
    @(negedge Clk);
    bus.dm_req = 1'b1; bus.dm_op = 6'b100011; bus.dm_rw = 1'b1; bus.dm_addr = 32'h40;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge Clk); cyc++;
      if (bus.dm_ack) begin
        got = 1'b1;
        check("to_err", 32'(bus.dm_err), 32'h1);
        check("to_rdata", bus.dm_rdata, 32'h0);
        check("to_mov", 32'(bus.mem_mov), 32'h0);
        check("to_latency", cyc, 19);
        bus.dm_req = 1'b0; last_dm = 1'b1;
      end
    end
    check("to_done", 32'(got), 32'h1);
    moc_block = 1'b0; delay = 0;
    txn(0, 1, 32'h0, 6'b100011, 1'b1, 32'h80, 32'h0);
`else
    sz = 0; cyc = 0; got = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
